led_pwm_bank: RTL and testbench
===============================

// Module: led_pwm_bank
// PURPOSE
//  Parametrised successor to the single-register custom LED peripheral: Avalon-MM slave on the
//  HPS lightweight bridge driving N_CH LED outputs, each with independent 8-bit PWM brightness
//  and a hardware blink mode. Sits in soc_system; leds[] is exported to the board LED pins.
//  Register writes are shadowed and applied at PWM frame boundaries, so LEDs never glitch.
// PARAMETERS
//  N_CH      8   number of LED channels (1..14)
//  PWM_BITS  8   PWM counter/duty width; frame = 2^PWM_BITS ticks
//  ADDR_W    4   Avalon word-address width; must satisfy 2^ADDR_W >= N_CH+2
// PORTS
//  clk            in   1        system clock (50 MHz)
//  reset_n        in   1        asynchronous active-low reset
//  avs_address    in   ADDR_W   word address
//  avs_write      in   1        write strobe, single cycle, no waitrequest
//  avs_writedata  in   32       write data
//  avs_read       in   1        read strobe
//  avs_readdata   out  32       read data, valid cycle after avs_read
//  leds           out  N_CH     LED drive, active high, registered
// BEHAVIOUR
//  Register map (word addr):
//   0 CTRL     [0] global enable; [1] frame-sync flag (RO, set each frame end, cleared on CTRL read)
//   1 PRESCALE [15:0] tick divider; a tick occurs every PRESCALE+1 clocks
//   2+c CH[c]  [1:0] mode (0 off, 1 on, 2 PWM, 3 blink); [PWM_BITS+7:8] duty; [31:16] blink half-period
//   Unmapped addresses: writes ignored, reads return 0.
//  Reset: leds=0, avs_readdata=0, all registers, shadows and counters 0, blink phase=on.
//  Reads: 1-cycle latency; readdata returns the written (not shadow) value; holds between reads.
//  Prescaler: cnt counts 0..PRESCALE; tick when cnt==PRESCALE, then cnt=0. PRESCALE written
//   below current cnt: cnt wraps to 0 next cycle (no 65536-cycle stall).
//  PWM: pwm_cnt (PWM_BITS) increments per tick, wraps 2^PWM_BITS-1 -> 0; wrap tick = frame end.
//   Per channel: pwm_on = (pwm_cnt < duty_shadow); duty 0 -> always low, max -> (2^PWM_BITS-1)/2^PWM_BITS.
//  Shadow: CH[c] and CTRL[0] copy to shadow regs only on frame-end tick. Write on the
//   same cycle as frame end: NEW value is captured into shadow.
//  Blink: per-channel 16-bit frame counter; increments on frame end in mode 3; on reaching
//   half-period-1, clears and toggles phase. Half-period 0 -> behaves as mode 2. Leaving mode 3
//   clears counter and sets phase=on.
//  Output (registered, 1 clk after decision): enable=0 -> 0; mode0 -> 0; mode1 -> 1;
//   mode2 -> pwm_on; mode3 -> pwm_on & phase.
//  Reset mid-frame: all state returns to reset values immediately (async); leds low same instant.
// CONFIGURATION
//  LED_BREATHE_EN defined: mode 3 with CH[c][31] set becomes breathing: effective duty ramps
//   0 -> duty -> 0 by 1 LSB per frame end, repeating; half-period field [30:16] ignored.
//   Ramp register per channel reset to 0, rising.
//  LED_BREATHE_EN undefined: bit 31 ignored (treated as part of half-period); no ramp logic.
// TESTING
//  T1 reset: reset_n low mid-operation -> leds==0, readdata==0, CTRL read ==0 after release.
//  T2 PWM: PRESCALE=0, enable=1, CH0 mode2 duty=64 -> leds[0] high exactly 64 of every 256 clocks
//   after first frame end.
//  T3 shadow: change CH0 duty 64->192 mid-frame -> old duty until next pwm_cnt wrap, no partial pulse.
//  T4 blink: PRESCALE=0, CH1 mode3 duty=255 half=2 -> leds[1] PWM-active for 512 clocks, low 512, repeat.
//  T5 map: write all N_CH+2 regs, read back identical; read addr N_CH+2 -> 0; CTRL[1] set then clear on read.
//  T6 (LED_BREATHE_EN) CH2 mode3 bit31 duty=4 -> per-frame high counts 0,1,2,3,4,3,2,1,0,...

Source files
------------

// File: rtl/led_pwm_bank_if.sv
// Avalon-MM slave bus bundle for led_pwm_bank: word address, write/read strobes, data.
interface led_pwm_bank_if #(parameter int ADDR_W = 4);
  logic [ADDR_W-1:0] avs_address;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic              avs_read;
  logic [31:0]       avs_readdata;

  modport master (output avs_address, avs_write, avs_writedata, avs_read,
                  input  avs_readdata);
  modport slave  (input  avs_address, avs_write, avs_writedata, avs_read,
                  output avs_readdata);
endinterface

// File: rtl/led_pwm_bank.sv
// N_CH-channel LED PWM/blink bank behind an Avalon-MM slave; settings are shadowed at frame end.
// Optional LED_BREATHE_EN: mode 3 with CH[c][31] set ramps duty 0->duty->0 per frame.
module led_pwm_lane #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                frame_end,
  input  logic                en,
  input  logic [1:0]          mode_nxt,
  input  logic [PWM_BITS-1:0] duty_nxt,
  input  logic [15:0]         hp_nxt,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led
);
  logic [1:0]          mode_sh;
  logic [PWM_BITS-1:0] duty_sh, eff_duty;
  logic [15:0]         hp_sh, half, bcnt;
  logic                phase, blink_act, pwm_on;

`ifdef LED_BREATHE_EN
  logic                breathe, fall;
  logic [PWM_BITS-1:0] ramp;
  assign breathe   = (mode_sh == 2'd3) && hp_sh[15];
  assign half      = {1'b0, hp_sh[14:0]};
  assign eff_duty  = breathe ? ramp : duty_sh;
  assign blink_act = (mode_sh == 2'd3) && (half != '0) && !breathe;

  // Triangle ramp: each endpoint is held for exactly one frame before turning.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ramp <= '0;
      fall <= 1'b0;
    end else if (!breathe || (frame_end && duty_sh == '0)) begin
      ramp <= '0;
      fall <= 1'b0;
    end else if (frame_end) begin
      if (!fall) begin
        if (ramp >= duty_sh) begin
          fall <= 1'b1;
          ramp <= ramp - 1'b1;
        end else ramp <= ramp + 1'b1;
      end else begin
        if (ramp == '0) begin
          fall <= 1'b0;
          ramp <= ramp + 1'b1;
        end else ramp <= ramp - 1'b1;
      end
    end
  end
`else
  assign half      = hp_sh;
  assign eff_duty  = duty_sh;
  assign blink_act = (mode_sh == 2'd3) && (half != '0);
`endif

  assign pwm_on = pwm_cnt < eff_duty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_sh <= '0;
      duty_sh <= '0;
      hp_sh   <= '0;
      bcnt    <= '0;
      phase   <= 1'b1;
      led     <= 1'b0;
    end else begin
      if (frame_end) begin
        mode_sh <= mode_nxt;
        duty_sh <= duty_nxt;
        hp_sh   <= hp_nxt;
      end
      // Blink state follows the mode of the frame that is ending.
      if (!blink_act) begin
        bcnt  <= '0;
        phase <= 1'b1;
      end else if (frame_end) begin
        if (bcnt == half - 16'd1) begin
          bcnt  <= '0;
          phase <= ~phase;
        end else bcnt <= bcnt + 16'd1;
      end
      unique case (mode_sh)
        2'd0:    led <= 1'b0;
        2'd1:    led <= en;
        2'd2:    led <= en & pwm_on;
        default: led <= en & pwm_on & phase;
      endcase
    end
  end
endmodule

module led_pwm_bank #(
  parameter int N_CH     = 8,
  parameter int PWM_BITS = 8,
  parameter int ADDR_W   = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  led_pwm_bank_if.slave       bus,
  output logic [N_CH-1:0]     leds
);
  localparam logic [ADDR_W-1:0] A_CTRL = '0;
  localparam logic [ADDR_W-1:0] A_PRE  = ADDR_W'(1);

  logic                       en, en_nxt, en_sh, flag;
  logic [15:0]                prescale, cnt;
  logic [PWM_BITS-1:0]        pwm_cnt;
  logic [N_CH-1:0][31:0]      ch_reg, ch_nxt;
  logic [31:0]                rd_val, rdata;
  logic                       tick, frame_end;

  assign tick      = (cnt == prescale);
  assign frame_end = tick && (&pwm_cnt);
  assign bus.avs_readdata = rdata;

  // Register values as they will be after this cycle's write, so a write
  // landing on the frame-end cycle is what the shadows pick up.
  always_comb begin
    en_nxt = en;
    ch_nxt = ch_reg;
    if (bus.avs_write) begin
      if (bus.avs_address == A_CTRL) en_nxt = bus.avs_writedata[0];
      for (int c = 0; c < N_CH; c++)
        if (bus.avs_address == ADDR_W'(c + 2)) ch_nxt[c] = bus.avs_writedata;
    end
  end

  always_comb begin
    rd_val = '0;
    if (bus.avs_address == A_CTRL)     rd_val = {30'd0, flag, en};
    else if (bus.avs_address == A_PRE) rd_val = {16'd0, prescale};
    for (int c = 0; c < N_CH; c++)
      if (bus.avs_address == ADDR_W'(c + 2)) rd_val = ch_reg[c];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en       <= 1'b0;
      en_sh    <= 1'b0;
      flag     <= 1'b0;
      prescale <= '0;
      ch_reg   <= '0;
      cnt      <= '0;
      pwm_cnt  <= '0;
      rdata    <= '0;
    end else begin
      en     <= en_nxt;
      ch_reg <= ch_nxt;
      if (bus.avs_write && bus.avs_address == A_PRE) prescale <= bus.avs_writedata[15:0];
      if (frame_end) en_sh <= en_nxt;
      // ">=" lets a PRESCALE lowered below cnt wrap immediately.
      cnt <= (cnt >= prescale) ? '0 : cnt + 16'd1;
      if (tick) pwm_cnt <= pwm_cnt + 1'b1;
      if (frame_end) flag <= 1'b1;
      else if (bus.avs_read && bus.avs_address == A_CTRL) flag <= 1'b0;
      if (bus.avs_read) rdata <= rd_val;
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_lane
    led_pwm_lane #(.PWM_BITS(PWM_BITS)) u_lane (
      .clk      (clk),
      .reset_n  (reset_n),
      .frame_end(frame_end),
      .en       (en_sh),
      .mode_nxt (ch_nxt[c][1:0]),
      .duty_nxt (ch_nxt[c][PWM_BITS+7:8]),
      .hp_nxt   (ch_nxt[c][31:16]),
      .pwm_cnt  (pwm_cnt),
      .led      (leds[c])
    );
  end
endmodule

// File: tb/tb_led_pwm_bank.sv
// Randomized bench for led_pwm_bank against a frame-level behavioural model, plus literal duty/blink checks.
module tb_led_pwm_bank;
  localparam int N_CH = 8, PWM_BITS = 8, ADDR_W = 4;
  localparam int FRAME = 1 << PWM_BITS;

  logic clk = 0, reset_n = 0;
  logic [N_CH-1:0] leds;
  led_pwm_bank_if #(.ADDR_W(ADDR_W)) bus();
  led_pwm_bank #(.N_CH(N_CH), .PWM_BITS(PWM_BITS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .leds(leds));

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  // Behavioural model: counters as plain integers, registers and shadows as arrays.
  bit          m_en, m_en_sh, m_flag;
  int          m_pre, m_cnt, m_pwm;
  logic [31:0] m_ch[N_CH], m_sh[N_CH];
  int          m_bc[N_CH];
  bit          m_ph[N_CH];
  logic [N_CH-1:0] m_leds;
  logic [31:0] m_rd;

  function automatic void m_reset();
    m_en = 0; m_en_sh = 0; m_flag = 0; m_pre = 0; m_cnt = 0; m_pwm = 0;
    m_leds = '0; m_rd = '0;
    for (int c = 0; c < N_CH; c++) begin
      m_ch[c] = '0; m_sh[c] = '0; m_bc[c] = 0; m_ph[c] = 1;
    end
  endfunction

  function automatic logic [31:0] m_read(int a);
    if (a == 0) return {30'd0, m_flag, m_en};
    if (a == 1) return 32'(m_pre);
    if (a >= 2 && a < N_CH + 2) return m_ch[a-2];
    return '0;
  endfunction

  function automatic void m_step();
    logic [N_CH-1:0] nl;
    int a, mode, duty, half, old_pre;
    bit tick, fe, on;
    for (int c = 0; c < N_CH; c++) begin
      mode = int'(m_sh[c][1:0]); duty = int'(m_sh[c][15:8]); half = int'(m_sh[c][31:16]);
      on = (m_pwm < duty);
      case (mode)
        0: nl[c] = 0;
        1: nl[c] = 1;
        2: nl[c] = on;
        default: nl[c] = on && m_ph[c];
      endcase
    end
    if (!m_en_sh) nl = '0;
    tick = (m_cnt == m_pre);
    fe = tick && (m_pwm == FRAME - 1);
    a = int'(bus.avs_address);
    if (bus.avs_read) m_rd = m_read(a);
    if (fe) m_flag = 1; else if (bus.avs_read && a == 0) m_flag = 0;
    for (int c = 0; c < N_CH; c++) begin
      mode = int'(m_sh[c][1:0]); half = int'(m_sh[c][31:16]);
      if (mode != 3 || half == 0) begin m_bc[c] = 0; m_ph[c] = 1; end
      else if (fe) begin
        if (m_bc[c] == half - 1) begin m_bc[c] = 0; m_ph[c] = !m_ph[c]; end
        else m_bc[c]++;
      end
    end
    old_pre = m_pre;
    if (bus.avs_write) begin
      if (a == 0) m_en = bus.avs_writedata[0];
      else if (a == 1) m_pre = int'(bus.avs_writedata[15:0]);
      else if (a < N_CH + 2) m_ch[a-2] = bus.avs_writedata;
    end
    if (fe) begin
      m_en_sh = m_en;
      for (int c = 0; c < N_CH; c++) m_sh[c] = m_ch[c];
    end
    m_cnt = (m_cnt >= old_pre) ? 0 : m_cnt + 1;
    if (tick) m_pwm = (m_pwm + 1) % FRAME;
    m_leds = nl;
  endfunction

  always @(posedge clk) if (reset_n) m_step();
  always @(negedge reset_n) m_reset();

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (reset_n) begin
    check("leds", 32'(leds), 32'(m_leds));
    check("readdata", bus.avs_readdata, m_rd);
  end

  task automatic wr(int a, logic [31:0] d);
    @(negedge clk);
    bus.avs_address = a[ADDR_W-1:0]; bus.avs_writedata = d; bus.avs_write = 1;
    @(negedge clk);
    bus.avs_write = 0;
  endtask

  task automatic rd(int a, output logic [31:0] d);
    @(negedge clk);
    bus.avs_address = a[ADDR_W-1:0]; bus.avs_read = 1;
    @(negedge clk);
    bus.avs_read = 0;
    d = bus.avs_readdata;
  endtask

  task automatic count_hi(int c, int n, output int k);
    k = 0;
    repeat (n) begin @(negedge clk); k += int'(leds[c]); end
  endtask

  function automatic logic [31:0] rnd_ch();
    logic [31:0] v;
    v = $urandom;
    if ($urandom_range(3) != 0) v[31:16] = 16'($urandom_range(3));
    return v;
  endfunction

  task automatic random_ops(int n);
    logic [31:0] d;
    int a;
    repeat (n) begin
      case ($urandom_range(3))
        0: begin a = $urandom_range(N_CH + 1) + 2; if (a > N_CH + 1) a = 15; wr(a, rnd_ch()); end
        1: wr($urandom_range(1), ($urandom_range(4) == 0) ? 32'(0) : 32'($urandom_range(2)) | 32'h1);
        2: begin rd($urandom_range(15), d); end
        default: repeat ($urandom_range(40)) @(negedge clk);
      endcase
    end
  endtask

  logic [31:0] wexp[N_CH];
  logic [31:0] d;
  int k;

  initial begin
    bus.avs_address = '0; bus.avs_write = 0; bus.avs_writedata = '0; bus.avs_read = 0;
    m_reset();
    repeat (3) @(negedge clk);
    check("rst_leds", 32'(leds), 0);
    check("rst_readdata", bus.avs_readdata, 0);
    reset_n = 1;
    rd(0, d); check("ctrl_after_rst", d, 0);

    // Register map readback
    for (int c = 0; c < N_CH; c++) begin wexp[c] = $urandom; wr(c + 2, wexp[c]); end
    wr(1, 32'h0000_00ab);
    for (int c = 0; c < N_CH; c++) begin rd(c + 2, d); check("map_ch", d, wexp[c]); end
    rd(1, d); check("map_prescale", d, 32'h0000_00ab);
    rd(N_CH + 2, d); check("map_unmapped", d, 0);
    rd(15, d); check("map_top", d, 0);

    // PWM duty 64 with prescale 0
    for (int c = 0; c < N_CH; c++) wr(c + 2, 0);
    wr(1, 0);
    wr(0, 1);
    wr(2, 32'h0000_4002);
    repeat (600) @(negedge clk);
    count_hi(0, FRAME, k); check("t2_duty64", 32'(k), 64);

    // Mid-frame duty change
    repeat (100) @(negedge clk);
    wr(2, 32'h0000_c002);
    repeat (600) @(negedge clk);
    count_hi(0, FRAME, k); check("t3_duty192", 32'(k), 192);

    // Blink: duty 255, half-period 2 frames -> 2 frames on, 2 off
    wr(3, 32'h0002_ff03);
    repeat (700) @(negedge clk);
    count_hi(1, 8 * FRAME, k); check("t4_blink", 32'(k), 4 * 255);

    // Frame-sync flag: slow the prescaler so no frame end lands between reads
    rd(0, d);
    repeat (300) @(negedge clk);
    wr(1, 32'h0000_ffff);
    rd(0, d); check("flag_set", 32'(d[1]), 1);
    rd(0, d); check("flag_clr", 32'(d[1]), 0);
    wr(1, 0);

    random_ops(500);

    // Asynchronous reset mid-operation
    wr(0, 1); wr(4, 32'h0000_0001);
    repeat (300) @(negedge clk);
    #2 reset_n = 0;
    #1 check("mid_rst_leds", 32'(leds), 0);
    check("mid_rst_readdata", bus.avs_readdata, 0);
    @(negedge clk); @(negedge clk);
    reset_n = 1;
    rd(0, d); check("ctrl_after_mid_rst", d, 0);

    random_ops(200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
